alu_op_sequencer: RTL

- Multi-cycle control sequencer that initiates operations on the datapath ALU.
- Accepts a decoded register-register instruction and drives the register-file read selects, the Y/Z register load strobes and the 4-bit ALU op code.
- Waits on the ALU for multiply/divide and issues writeback strobes to the destination register, or to HI/LO for 64-bit results.
- Sits between instruction decode and the datapath bus.

---
 rtl/alu_op_sequencer_if.sv | 39 +++
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between decode/ALU and the operation sequencer.
// The sequencer takes the slave modport; the decode/datapath side takes the master modport.
interface alu_op_sequencer_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  start;
  logic [3:0]            opcode;
  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
  logic [REG_ADDR_W-1:0] rc;
  logic                  alu_done;
  logic                  busy;
  logic [REG_ADDR_W-1:0] rf_out_sel;
  logic                  rf_out_en;
  logic [REG_ADDR_W-1:0] rf_in_sel;
  logic                  rf_in_en;
  logic                  y_in;
  logic                  z_in;
  logic [3:0]            alu_op;
  logic                  z_lo_out;
  logic                  z_hi_out;
  logic                  lo_in;
  logic                  hi_in;
  logic                  done;
  logic                  err;
  logic [31:0]           retired;

  modport slave (
    input  start, opcode, ra, rb, rc, alu_done,
    output busy, rf_out_sel, rf_out_en, rf_in_sel, rf_in_en, y_in, z_in,
           alu_op, z_lo_out, z_hi_out, lo_in, hi_in, done, err, retired
  );

  modport master (
    output start, opcode, ra, rb, rc, alu_done,
    input  busy, rf_out_sel, rf_out_en, rf_in_sel, rf_in_en, y_in, z_in,
           alu_op, z_lo_out, z_hi_out, lo_in, hi_in, done, err, retired
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving register-file selects, Y/Z/HI/LO strobes and the ALU op code.
// Optional retired-instruction counter enabled by macro ALU_OP_SEQUENCER_RETIRE_CNT_EN.
module alu_op_sequencer #(
  parameter int REG_ADDR_W     = 4,
  parameter int MULDIV_TIMEOUT = 64
) (
  input logic               clock,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Y, S_EXEC, S_WAIT, S_WB_LO, S_WB_HI, S_ERR
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MULDIV_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  is_muldiv, is_binary, done_s;

  assign is_muldiv = (op_q == 4'd2) || (op_q == 4'd3);
  assign is_binary = (op_q <= 4'd5);

  always_comb begin
    // NOTE: every target is defaulted first so no path through the case can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        op_d    = bus.opcode;
        ra_d    = bus.ra;
        rb_d    = bus.rb;
        rc_d    = bus.rc;
        state_d = (bus.opcode > 4'd10) ? S_ERR : S_LOAD_Y;
      end
      S_LOAD_Y: state_d = S_EXEC;
      S_EXEC: begin
        cnt_d   = '0;
        state_d = is_muldiv ? S_WAIT : S_WB_LO;
      end
      S_WAIT: begin
        // A late alu_done on the final budgeted cycle still completes the op.
        if (bus.alu_done)               state_d = S_WB_LO;
        else if (cnt_q == TIMEOUT_LAST) state_d = S_ERR;
        else                            cnt_d   = cnt_q + 8'd1;
      end
      S_WB_LO: state_d = is_muldiv ? S_WB_HI : S_IDLE;
      S_WB_HI: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.busy       = (state_q != S_IDLE);
    bus.rf_out_sel = '0;
    bus.rf_out_en  = 1'b0;
    bus.rf_in_sel  = '0;
    bus.rf_in_en   = 1'b0;
    bus.y_in       = 1'b0;
    bus.z_in       = 1'b0;
    bus.alu_op     = 4'd0;
    bus.z_lo_out   = 1'b0;
    bus.z_hi_out   = 1'b0;
    bus.lo_in      = 1'b0;
    bus.hi_in      = 1'b0;
    bus.err        = 1'b0;
    done_s         = 1'b0;
    case (state_q)
      S_LOAD_Y: begin
        bus.rf_out_en  = 1'b1;
        bus.rf_out_sel = rb_q;
        bus.y_in       = 1'b1;
      end
      S_EXEC: begin
        bus.alu_op = op_q;
        bus.z_in   = !is_muldiv;
        if (is_binary) begin
          bus.rf_out_en  = 1'b1;
          bus.rf_out_sel = rc_q;
        end
      end
      S_WAIT: begin
        // Z must capture the product/quotient in the very cycle the ALU flags it valid.
        bus.alu_op     = op_q;
        bus.rf_out_en  = 1'b1;
        bus.rf_out_sel = rc_q;
        bus.z_in       = bus.alu_done;
      end
      S_WB_LO: begin
        bus.z_lo_out = 1'b1;
        if (is_muldiv) begin
          bus.lo_in = 1'b1;
        end else begin
          bus.rf_in_en  = 1'b1;
          bus.rf_in_sel = ra_q;
          done_s        = 1'b1;
        end
      end
      S_WB_HI: begin
        bus.z_hi_out = 1'b1;
        bus.hi_in    = 1'b1;
        done_s       = 1'b1;
      end
      S_ERR:   bus.err = 1'b1;
      default: ;
    endcase
  end

  assign bus.done = done_s;

`ifdef ALU_OP_SEQUENCER_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = retired_q + {31'd0, done_s};

  always_ff @(posedge clock) begin
    if (clear) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = 32'd0;
`endif
endmodule
